// File: rtl/simon_core_param.sv
// Parametrised Simon Says engine: LFSR-grown sequence, LED playback, press checking.
// Optional input timeout in WAIT_IN is enabled by defining SIMON_TIMEOUT_EN.
module simon_core_param #(
  parameter int unsigned N_BUTTONS     = 16,
  parameter int unsigned MAX_LEVEL     = 16,
  parameter int unsigned SHOW_TICKS    = 50,
  parameter int unsigned GAP_TICKS     = 25,
  parameter logic [15:0] SEED          = 16'hACE1,
  parameter int unsigned TIMEOUT_TICKS = 500
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic [N_BUTTONS-1:0]             in,
  output logic [N_BUTTONS-1:0]             led_out,
  output logic [$clog2(MAX_LEVEL+1)-1:0]   level,
  output logic [2:0]                       state,
  output logic                             blue,
  output logic                             green,
  output logic                             red
);

  localparam int unsigned LW    = $clog2(MAX_LEVEL + 1);
  localparam int unsigned BW    = $clog2(N_BUTTONS);
  localparam int unsigned AW    = (MAX_LEVEL > 1) ? $clog2(MAX_LEVEL) : 1;
  localparam int unsigned MAXT  = (SHOW_TICKS > GAP_TICKS) ? SHOW_TICKS : GAP_TICKS;
  localparam int unsigned TW    = $clog2(MAXT + 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_GEN      = 3'd1,
    S_SHOW_ON  = 3'd2,
    S_SHOW_OFF = 3'd3,
    S_WAIT_IN  = 3'd4,
    S_WIN      = 3'd5,
    S_LOSE     = 3'd6
  } state_t;

  state_t                cur_state, nxt_state;
  logic [15:0]           lfsr;
  logic [N_BUTTONS-1:0]  in_q;
  logic                  start_q;
  logic [BW-1:0]         seq [MAX_LEVEL];
  logic [LW-1:0]         idx, idx_nxt, level_nxt;
  logic [TW-1:0]         cnt, cnt_nxt;
  logic [N_BUTTONS-1:0]  echo, echo_nxt;
  logic [N_BUTTONS-1:0]  press;
  logic [BW-1:0]         btn, new_btn, cur_step;
  logic [7:0]            lfsr_mod;
  logic                  start_edge, seq_we, hit, last;

`ifdef SIMON_TIMEOUT_EN
  localparam int unsigned TOW = $clog2(TIMEOUT_TICKS + 1);
  logic [TOW-1:0] to_cnt, to_cnt_nxt;
`endif

  assign press      = in & ~in_q;
  assign start_edge = start & ~start_q;
  assign lfsr_mod   = lfsr[7:0] % 8'(N_BUTTONS);
  assign new_btn    = BW'(lfsr_mod);
  assign cur_step   = seq[idx[AW-1:0]];
  assign hit        = (btn == cur_step);
  assign last       = (idx == level - LW'(1));

  always_comb begin
    btn = '0;
    for (int unsigned i = 0; i < N_BUTTONS; i++)
      if (press[i]) btn = BW'(i);
  end

  always_comb begin
    nxt_state = cur_state;
    level_nxt = level;
    idx_nxt   = idx;
    cnt_nxt   = '0;
    echo_nxt  = '0;
    seq_we    = 1'b0;
`ifdef SIMON_TIMEOUT_EN
    to_cnt_nxt = '0;
`endif
    case (cur_state)
      S_IDLE, S_WIN, S_LOSE: begin
        if (start_edge) begin
          nxt_state = S_GEN;
          level_nxt = '0;
        end
      end
      S_GEN: begin
        seq_we    = 1'b1;
        level_nxt = level + LW'(1);
        idx_nxt   = '0;
        nxt_state = S_SHOW_ON;
      end
      S_SHOW_ON: begin
        if (cnt == TW'(SHOW_TICKS - 1)) nxt_state = S_SHOW_OFF;
        else                            cnt_nxt   = cnt + TW'(1);
      end
      S_SHOW_OFF: begin
        if (cnt == TW'(GAP_TICKS - 1)) begin
          if (last) begin
            nxt_state = S_WAIT_IN;
            idx_nxt   = '0;
          end else begin
            nxt_state = S_SHOW_ON;
            idx_nxt   = idx + LW'(1);
          end
        end else begin
          cnt_nxt = cnt + TW'(1);
        end
      end
      S_WAIT_IN: begin
        // Press handling is checked before timeout so a press on the final tick wins.
        if (press != '0) begin
          if ($countones(press) > 1) begin
            nxt_state = S_LOSE;
          end else begin
            echo_nxt = {{(N_BUTTONS-1){1'b0}}, 1'b1} << btn;
            if (!hit)                          nxt_state = S_LOSE;
            else if (!last)                    idx_nxt   = idx + LW'(1);
            else if (level == LW'(MAX_LEVEL))  nxt_state = S_WIN;
            else                               nxt_state = S_GEN;
          end
        end else begin
`ifdef SIMON_TIMEOUT_EN
          if (to_cnt == TOW'(TIMEOUT_TICKS - 1)) nxt_state  = S_LOSE;
          else                                   to_cnt_nxt = to_cnt + TOW'(1);
`endif
        end
      end
      default: nxt_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_state <= S_IDLE;
      lfsr      <= SEED;
      in_q      <= '0;
      start_q   <= 1'b0;
      level     <= '0;
      idx       <= '0;
      cnt       <= '0;
      echo      <= '0;
`ifdef SIMON_TIMEOUT_EN
      to_cnt    <= '0;
`endif
    end else begin
      cur_state <= nxt_state;
      lfsr      <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      in_q      <= in;
      start_q   <= start;
      level     <= level_nxt;
      idx       <= idx_nxt;
      cnt       <= cnt_nxt;
      echo      <= echo_nxt;
`ifdef SIMON_TIMEOUT_EN
      to_cnt    <= to_cnt_nxt;
`endif
    end
  end

  // Sequence storage is never cleared; entries are only read below level.
  always_ff @(posedge clk) begin
    if (seq_we) seq[level[AW-1:0]] <= new_btn;
  end

  always_comb begin
    led_out = '0;
    if (cur_state == S_SHOW_ON)
      led_out = {{(N_BUTTONS-1){1'b0}}, 1'b1} << cur_step;
    else if (cur_state == S_WAIT_IN || cur_state == S_GEN)
      led_out = echo;
  end

  assign state = cur_state;
  assign blue  = (cur_state == S_SHOW_ON) || (cur_state == S_SHOW_OFF) || (cur_state == S_WAIT_IN);
  assign green = (cur_state == S_WIN);
  assign red   = (cur_state == S_LOSE);

endmodule
